mod_counter_ctrl: RTL and testbench

Programmable modulus counter with a run-control sequencer, replacing the fixed mod counter wherever software-set modulus, pause/stop or a bounded number of wraps is needed. Config is loaded through a valid/ready handshake, then a start/pause/stop FSM runs the counter. It reports terminal-count pulses, the completed wrap count and done/busy status.

---
 rtl/mod_counter_ctrl.sv | 117 +++++++++++
 tb/tb_mod_counter_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mod_counter_ctrl.sv
// Programmable modulus counter with start/pause/stop sequencing, terminal-count
// pulse, wrap counting and an optional wrap limit that ends the run in DONE.
//
// state  | meaning
// IDLE   | stopped, count/wrap_cnt cleared, config accepted
// RUN    | counting 0..term, one step per edge
// PAUSED | count and wrap_cnt held while pause is high
// DONE   | wrap limit reached, wrap_cnt holds final value, config accepted
module mod_counter_ctrl #(
  parameter int WIDTH   = 3,
  parameter int WRAPS_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_term,
  input  logic [WRAPS_W-1:0] cfg_wraps,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic [WRAPS_W-1:0] wrap_cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     term_r, count_nxt;
  logic [WRAPS_W-1:0]   wraps_r, wrap_nxt, wrap_inc;
  logic                 tc_nxt;
  logic                 cfg_load;

  assign cfg_ready = (state == IDLE) || (state == DONE);
  assign cfg_load  = cfg_valid && cfg_ready;
  assign busy      = (state == RUN) || (state == PAUSED);
  assign done      = (state == DONE);
  assign wrap_inc  = wrap_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    wrap_nxt  = wrap_cnt;
    tc_nxt    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (stop) begin
          state_nxt = IDLE;
          count_nxt = '0;
          wrap_nxt  = '0;
        end else if (!pause && start) begin
          state_nxt = RUN;
          count_nxt = '0;
          wrap_nxt  = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
          count_nxt = '0;
          wrap_nxt  = '0;
        end else if (pause) begin
          state_nxt = PAUSED;
        end else if (count != term_r) begin
          count_nxt = count + 1'b1;
        end else begin
          count_nxt = '0;
          wrap_nxt  = wrap_inc;
          tc_nxt    = 1'b1;
          // A zero limit means free-running; wrap_cnt then rolls over.
          if ((wraps_r != '0) && (wrap_inc == wraps_r)) state_nxt = DONE;
        end
      end
      PAUSED: begin
        if (stop) begin
          state_nxt = IDLE;
          count_nxt = '0;
          wrap_nxt  = '0;
        end else if (!pause) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
        wrap_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      wrap_cnt <= '0;
      tc       <= 1'b0;
      term_r   <= '1;
      wraps_r  <= '0;
    end else begin
      count    <= count_nxt;
      wrap_cnt <= wrap_nxt;
      tc       <= tc_nxt;
      if (cfg_load) begin
        term_r  <= cfg_term;
        wraps_r <= cfg_wraps;
      end
    end
  end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed bench for mod_counter_ctrl: a vector table of per-edge stimulus and
// expected outputs, plus hand sequences for async reset and wrap_cnt rollover.
module tb_mod_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready;
  logic [2:0] cfg_term;
  logic [3:0] cfg_wraps;
  logic       start, pause, stop;
  logic [2:0] count;
  logic       tc;
  logic [3:0] wrap_cnt;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  mod_counter_ctrl #(.WIDTH(3), .WRAPS_W(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_term(cfg_term), .cfg_wraps(cfg_wraps),
    .start(start), .pause(pause), .stop(stop),
    .count(count), .tc(tc), .wrap_cnt(wrap_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic [2:0] ct;
    logic [3:0] cw;
    logic       st, pa, sp;
    logic [2:0] ec;
    logic       etc;
    logic [3:0] ew;
    logic       eb, ed, er;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cv, input logic [2:0] ct, input logic [3:0] cw,
                     input logic st, input logic pa, input logic sp,
                     input logic [2:0] ec, input logic etc, input logic [3:0] ew,
                     input logic eb, input logic ed, input logic er);
    vec_t v;
    v.cv = cv; v.ct = ct; v.cw = cw; v.st = st; v.pa = pa; v.sp = sp;
    v.ec = ec; v.etc = etc; v.ew = ew; v.eb = eb; v.ed = ed; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] ec, input logic etc,
                       input logic [3:0] ew, input logic eb, input logic ed, input logic er);
    checks++;
    if (count !== ec || tc !== etc || wrap_cnt !== ew || busy !== eb ||
        done !== ed || cfg_ready !== er) begin
      errors++;
      $display("FAIL %s: got count=%0d tc=%0b wrap=%0d busy=%0b done=%0b ready=%0b, want count=%0d tc=%0b wrap=%0d busy=%0b done=%0b ready=%0b",
               name, count, tc, wrap_cnt, busy, done, cfg_ready, ec, etc, ew, eb, ed, er);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [2:0] ct, input logic [3:0] cw,
                       input logic st, input logic pa, input logic sp);
    cfg_valid = cv; cfg_term = ct; cfg_wraps = cw; start = st; pause = pa; stop = sp;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("reset", 0, 0, 0, 0, 0, 1);
    rst = 1'b0;

    // term=5 continuous, cfg ignored during RUN, then stop
    add(1,5,0,1,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0, 1,0,0,1,0,0);
    add(0,0,0,0,0,0, 2,0,0,1,0,0);
    add(0,0,0,0,0,0, 3,0,0,1,0,0);
    add(0,0,0,0,0,0, 4,0,0,1,0,0);
    add(0,0,0,0,0,0, 5,0,0,1,0,0);
    add(0,0,0,0,0,0, 0,1,1,1,0,0);
    add(1,1,0,0,0,0, 1,0,1,1,0,0);
    add(1,1,0,1,0,0, 2,0,1,1,0,0);
    add(0,0,0,0,0,0, 3,0,1,1,0,0);
    add(0,0,0,0,0,0, 4,0,1,1,0,0);
    add(0,0,0,0,0,0, 5,0,1,1,0,0);
    add(0,0,0,0,0,0, 0,1,2,1,0,0);
    add(0,0,0,0,0,1, 0,0,0,0,0,1);
    // term=7 pause at 3 for 4 edges, resume, pause, stop while paused
    add(1,7,0,1,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0, 1,0,0,1,0,0);
    add(0,0,0,0,0,0, 2,0,0,1,0,0);
    add(0,0,0,0,0,0, 3,0,0,1,0,0);
    add(0,0,0,0,1,0, 3,0,0,1,0,0);
    add(0,0,0,1,1,0, 3,0,0,1,0,0);
    add(0,0,0,0,1,0, 3,0,0,1,0,0);
    add(0,0,0,0,1,0, 3,0,0,1,0,0);
    add(0,0,0,0,0,0, 3,0,0,1,0,0);
    add(0,0,0,0,0,0, 4,0,0,1,0,0);
    add(0,0,0,0,1,0, 4,0,0,1,0,0);
    add(0,0,0,1,1,1, 0,0,0,0,0,1);
    // term=2 wraps=3 -> DONE after 9 edges
    add(1,2,3,1,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0, 1,0,0,1,0,0);
    add(0,0,0,0,0,0, 2,0,0,1,0,0);
    add(0,0,0,0,0,0, 0,1,1,1,0,0);
    add(0,0,0,0,0,0, 1,0,1,1,0,0);
    add(0,0,0,0,0,0, 2,0,1,1,0,0);
    add(0,0,0,0,0,0, 0,1,2,1,0,0);
    add(0,0,0,0,0,0, 1,0,2,1,0,0);
    add(0,0,0,0,0,0, 2,0,2,1,0,0);
    add(0,0,0,0,0,0, 0,1,3,0,1,1);
    add(0,0,0,0,0,0, 0,0,3,0,1,1);
    // new config with start in DONE: term=1 continuous
    add(1,1,0,1,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0, 1,0,0,1,0,0);
    add(0,0,0,0,0,0, 0,1,1,1,0,0);
    add(0,0,0,0,0,0, 1,0,1,1,0,0);
    add(0,0,0,0,0,0, 0,1,2,1,0,0);
    add(0,0,0,0,0,1, 0,0,0,0,0,1);
    // term=0 wraps=4
    add(1,0,4,1,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0,0, 0,1,1,1,0,0);
    add(0,0,0,0,0,0, 0,1,2,1,0,0);
    add(0,0,0,0,0,0, 0,1,3,1,0,0);
    add(0,0,0,0,0,0, 0,1,4,0,1,1);
    add(0,0,0,0,0,0, 0,0,4,0,1,1);
    add(0,0,0,0,0,1, 0,0,0,0,0,1);

    foreach (vecs[i]) begin
      drive(vecs[i].cv, vecs[i].ct, vecs[i].cw, vecs[i].st, vecs[i].pa, vecs[i].sp);
      step();
      check($sformatf("vec%0d", i), vecs[i].ec, vecs[i].etc, vecs[i].ew,
            vecs[i].eb, vecs[i].ed, vecs[i].er);
    end

    // term=0 free-running: wrap_cnt rolls over 15 -> 0, busy stays high
    drive(1, 0, 0, 1, 0, 0);
    step();
    check("run0_start", 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      step();
      check($sformatf("rollover%0d", i), 0, 1, 4'(i % 16), 1, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 1);
    step();
    check("rollover_stop", 0, 0, 0, 0, 0, 1);

    // async reset mid-run at count=4
    drive(1, 7, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    check("pre_reset", 4, 0, 0, 1, 0, 0);
    #2 rst = 1'b1;
    #1 check("async_reset", 0, 0, 0, 0, 0, 1);
    step();
    rst = 1'b0;
    step();
    check("post_reset_idle", 0, 0, 0, 0, 0, 1);
    // default term after reset is 7: start without cfg and count to 7, wrap
    drive(0, 0, 0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step();
    check("default_term_top", 7, 0, 0, 1, 0, 0);
    step();
    check("default_term_wrap", 0, 1, 1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
